// File: rtl/des_pkg.sv
// des_pkg: shared DES round-controller constants, FSM states and key-rotation helper.
package des_pkg;
    localparam int NUM_ROUNDS = 16;
    localparam int CNT_W = $clog2(NUM_ROUNDS);
    localparam logic [NUM_ROUNDS-1:0] SINGLE_SHIFT_MASK = 16'h8103;

    typedef enum logic [2:0] {IDLE, LOAD, ROUND, FINAL, DONE} des_ctrl_state_t;

    // Decrypt walks the encrypt schedule backwards, one round behind: round 0 leaves C/D as loaded.
    function automatic logic [1:0] shift_amt(input logic [CNT_W-1:0] idx, input logic decrypt);
        if (!decrypt)
            return SINGLE_SHIFT_MASK[idx] ? 2'd1 : 2'd2;
        if (idx == '0)
            return 2'd0;
        return SINGLE_SHIFT_MASK[CNT_W'(NUM_ROUNDS - int'(idx))] ? 2'd1 : 2'd2;
    endfunction
endpackage

// File: rtl/des_iter_ctrl.sv
// des_iter_ctrl: sequences load, 16 rounds, final permutation and output handshake of an iterative DES core.
module des_iter_ctrl
    import des_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    input  logic       decrypt_i,
    output logic       ld_o,
    output logic       round_en_o,
    output logic [3:0] round_idx_o,
    output logic [1:0] key_shift_o,
    output logic       key_dir_o,
    output logic       fp_en_o,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output logic       busy_o
);
    des_ctrl_state_t state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic mode;
    logic accept;

    assign in_ready_o = (state == IDLE) || (state == DONE && out_ready_i);
    assign accept = in_valid_i && in_ready_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            mode <= 1'b0;
        end else begin
            state <= state_nx;
            cnt <= (state == ROUND) ? cnt + 1'b1 : '0;
            if (accept)
                mode <= decrypt_i;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? LOAD : IDLE;
            LOAD:    state_nx = ROUND;
            ROUND:   state_nx = (cnt == CNT_W'(NUM_ROUNDS - 1)) ? FINAL : ROUND;
            FINAL:   state_nx = DONE;
            DONE:    state_nx = out_ready_i ? (in_valid_i ? LOAD : IDLE) : DONE;
            default: state_nx = IDLE;
        endcase
    end

    assign ld_o = (state == LOAD);
    assign round_en_o = (state == ROUND);
    assign round_idx_o = round_en_o ? cnt : '0;
    assign key_shift_o = round_en_o ? shift_amt(cnt, mode) : 2'd0;
    assign key_dir_o = mode;
    assign fp_en_o = (state == FINAL);
    assign out_valid_o = (state == DONE);
    assign busy_o = (state != IDLE);
endmodule

// File: tb/tb_des_iter_ctrl.sv
// tb_des_iter_ctrl: directed and random traffic checked against a cycles-since-acceptance timeline model.
module tb_des_iter_ctrl;
    logic clk = 1'b0;
    logic rst, in_valid_i, decrypt_i, out_ready_i;
    logic in_ready_o, ld_o, round_en_o, key_dir_o, fp_en_o, out_valid_o, busy_o;
    logic [3:0] round_idx_o;
    logic [1:0] key_shift_o;

    des_iter_ctrl dut (
        .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .decrypt_i(decrypt_i), .ld_o(ld_o), .round_en_o(round_en_o),
        .round_idx_o(round_idx_o), .key_shift_o(key_shift_o), .key_dir_o(key_dir_o),
        .fp_en_o(fp_en_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int enc_tab [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    int dec_tab [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    int tab_sum [2];
    // Model: a block is a timeline t = cycles since acceptance (1 load, 2..17 rounds, 18 fp, 19+ done).
    bit m_active = 0, m_mode = 0;
    int m_t = 0;
    int cyc = 0, shift_sum = 0;
    int ld_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        bit rnd;
        int ri;
        @(negedge clk);
        rnd = m_active && m_t >= 2 && m_t <= 17;
        ri = rnd ? m_t - 2 : 0;
        chk("in_ready", in_ready_o, !m_active || (m_t >= 19 && out_ready_i));
        chk("busy", busy_o, m_active);
        chk("ld", ld_o, m_active && m_t == 1);
        chk("round_en", round_en_o, rnd);
        chk("round_idx", round_idx_o, ri);
        chk("key_shift", key_shift_o, rnd ? (m_mode ? dec_tab[ri] : enc_tab[ri]) : 0);
        chk("key_dir", key_dir_o, m_mode);
        chk("fp_en", fp_en_o, m_active && m_t == 18);
        chk("out_valid", out_valid_o, m_active && m_t >= 19);
        if (ld_o) begin
            shift_sum = 0;
            ld_q.push_back(cyc);
        end
        if (round_en_o) shift_sum += int'(key_shift_o);
        if (fp_en_o) chk("shift_sum", shift_sum, tab_sum[m_mode]);
        @(posedge clk);
        if (rst) begin
            m_active = 0; m_t = 0; m_mode = 0;
        end else if (!m_active) begin
            if (in_valid_i) begin m_active = 1; m_t = 1; m_mode = decrypt_i; end
        end else if (m_t >= 19) begin
            if (out_ready_i && in_valid_i) begin m_t = 1; m_mode = decrypt_i; end
            else if (out_ready_i) m_active = 0;
        end else m_t++;
        cyc++;
        #1;
    endtask

    task automatic request(input bit dec);
        in_valid_i = 1; decrypt_i = dec;
        tick();
        in_valid_i = 0; decrypt_i = $urandom_range(0, 1);
    endtask

    initial begin
        int ov_cnt, guard;
        tab_sum = '{0, 0};
        for (int i = 0; i < 16; i++) begin
            tab_sum[0] += enc_tab[i];
            tab_sum[1] += dec_tab[i];
        end
        rst = 1; in_valid_i = 0; decrypt_i = 0; out_ready_i = 1;
        @(posedge clk); @(posedge clk); #1;
        repeat (2) tick();
        rst = 0;
        repeat (2) tick();
        // single encrypt then single decrypt
        request(0);
        repeat (24) tick();
        request(1);
        repeat (24) tick();
        // backpressure for 10 cycles once the result is ready
        out_ready_i = 0;
        request(0);
        ov_cnt = 0;
        repeat (28) begin
            if (out_valid_o) ov_cnt++;
            tick();
        end
        chk("bp_hold", ov_cnt, 10);
        out_ready_i = 1;
        repeat (3) tick();
        // back-to-back traffic
        ld_q.delete();
        in_valid_i = 1; decrypt_i = 0;
        repeat (60) begin
            tick();
            decrypt_i = $urandom_range(0, 1);
        end
        in_valid_i = 0;
        repeat (22) tick();
        chk("b2b_lds", ld_q.size() >= 3, 1);
        if (ld_q.size() >= 3) begin
            chk("b2b_gap1", ld_q[1] - ld_q[0], 19);
            chk("b2b_gap2", ld_q[2] - ld_q[0], 38);
        end
        // reset while round 7 is on the bus
        request(1);
        guard = 0;
        while (!(m_active && m_t == 9) && guard < 40) begin
            tick();
            guard++;
        end
        chk("rst_reach_r7", round_idx_o, 7);
        rst = 1;
        tick();
        rst = 0;
        tick();
        request(0);
        repeat (22) tick();
        // stray valid during rounds is ignored
        ld_q.delete();
        request(0);
        repeat (5) tick();
        in_valid_i = 1;
        tick();
        in_valid_i = 0;
        repeat (20) tick();
        chk("stray_lds", ld_q.size(), 1);
        // random traffic
        repeat (3000) begin
            in_valid_i = ($urandom_range(0, 9) < 3);
            decrypt_i = $urandom_range(0, 1);
            out_ready_i = ($urandom_range(0, 9) < 6);
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
